token_parser: RTL

TOKEN_PARSER -- requirements
Module: token_parser

---
 rtl/token_parser.sv | 135 +++++++++++++
 1 files changed

// File: rtl/token_parser.sv
// ASCII token parser: turns a byte stream of decimal numbers, operators and line
// breaks into registered token beats with line tracking and sticky error flags.
module token_parser #(
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned LINE_WIDTH  = 8
) (
    input  logic                   tck,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   tok_valid,
    output logic                   tok_has_num,
    output logic [VALUE_WIDTH-1:0] tok_value,
    output logic [1:0]             tok_term,
    output logic [LINE_WIDTH-1:0]  tok_line,
    output logic                   overflow,
    output logic                   bad_char
);

    localparam int unsigned WIDE_W = VALUE_WIDTH + 4;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] NUMBER = 1'b1;

    localparam logic [1:0] TERM_SPACE = 2'b00;
    localparam logic [1:0] TERM_PLUS  = 2'b01;
    localparam logic [1:0] TERM_STAR  = 2'b10;
    localparam logic [1:0] TERM_EOL   = 2'b11;

    logic [0:0]             state_q, state_d;
    logic [VALUE_WIDTH-1:0] acc_q, acc_d;
    logic [LINE_WIDTH-1:0]  line_cnt_q, line_cnt_d;

    logic                   valid_d;
    logic                   has_num_d;
    logic [VALUE_WIDTH-1:0] value_d;
    logic [1:0]             term_d;
    logic [LINE_WIDTH-1:0]  line_d;
    logic                   overflow_d;
    logic                   bad_char_d;

    logic                   is_digit, is_space, is_plus, is_star, is_lf, is_cr, is_bad;
    logic [WIDE_W-1:0]      wide;

    // Byte classification
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_space = (in_data == 8'h20);
    assign is_plus  = (in_data == 8'h2B);
    assign is_star  = (in_data == 8'h2A);
    assign is_lf    = (in_data == 8'h0A);
    assign is_cr    = (in_data == 8'h0D);
    assign is_bad   = !(is_digit || is_space || is_plus || is_star || is_lf || is_cr);

    // Widened accumulate so any carry out of VALUE_WIDTH is visible
    assign wide = WIDE_W'(acc_q) * WIDE_W'(10) + WIDE_W'(in_data[3:0]);

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            line_cnt_q  <= '0;
            tok_valid   <= 1'b0;
            tok_has_num <= 1'b0;
            tok_value   <= '0;
            tok_term    <= TERM_SPACE;
            tok_line    <= '0;
            overflow    <= 1'b0;
            bad_char    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            line_cnt_q  <= line_cnt_d;
            tok_valid   <= valid_d;
            tok_has_num <= has_num_d;
            tok_value   <= value_d;
            tok_term    <= term_d;
            tok_line    <= line_d;
            overflow    <= overflow_d;
            bad_char    <= bad_char_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        line_cnt_d = line_cnt_q;
        valid_d    = 1'b0;
        has_num_d  = tok_has_num;
        value_d    = tok_value;
        term_d     = tok_term;
        line_d     = tok_line;
        overflow_d = overflow;
        bad_char_d = bad_char;

        if (in_valid && !is_cr) begin
            if (is_digit) begin
                if (state_q == IDLE) begin
                    acc_d   = VALUE_WIDTH'(in_data[3:0]);
                    state_d = NUMBER;
                end else if (wide[WIDE_W-1:VALUE_WIDTH] != '0) begin
                    acc_d      = '1;
                    overflow_d = 1'b1;
                end else begin
                    acc_d = wide[VALUE_WIDTH-1:0];
                end
            end else begin
                if (is_bad) begin
                    bad_char_d = 1'b1;
                end
                if (state_q == NUMBER) begin
                    // Invalid bytes terminate a number like a space
                    valid_d   = 1'b1;
                    has_num_d = 1'b1;
                    value_d   = acc_q;
                    line_d    = line_cnt_q;
                    term_d    = is_lf   ? TERM_EOL  :
                                is_plus ? TERM_PLUS :
                                is_star ? TERM_STAR : TERM_SPACE;
                    acc_d     = '0;
                    state_d   = IDLE;
                end else if (is_plus || is_star || is_lf) begin
                    valid_d   = 1'b1;
                    has_num_d = 1'b0;
                    value_d   = '0;
                    line_d    = line_cnt_q;
                    term_d    = is_lf ? TERM_EOL : (is_plus ? TERM_PLUS : TERM_STAR);
                end
                if (is_lf) begin
                    line_cnt_d = line_cnt_q + LINE_WIDTH'(1);
                end
            end
        end
    end

endmodule
